// File: rtl/ps2_pkg.sv
// Shared constants, decode-state encoding and key-event record for the PS/2 key decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_ERR_00 = 8'h00;
   localparam logic [7:0] PS2_ERR_FF = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } dec_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       is_release;
   } key_event_t;

   // Odd parity holds when data plus parity bit contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

   function automatic logic is_err_code(input logic [7:0] b);
      return (b == PS2_ERR_00) || (b == PS2_ERR_FF);
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchroniser, falling-edge sampler, 11-bit framing and idle timeout.
// Start/stop/parity checking is compiled in only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_stb,
   output logic       rx_err
);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [2:0]       clk_sync;
   logic [2:0]       data_sync;
   logic [3:0]       bit_cnt;
   logic [9:0]       shift;
   logic [TMO_W-1:0] tmo_cnt;
   logic             fall;
   logic [10:0]      frame;
   logic             frame_good;

   assign fall = clk_sync[2] & ~clk_sync[1];

   // Oldest bit (start) ends up in frame[0]; the stop bit is the one sampled now.
   assign frame      = {data_sync[2], shift};
   assign frame_good = ~frame[0] & frame[10] & odd_parity_ok(frame[9:1]);

   always_ff @(posedge clk) begin
      if (!clrn) begin
         clk_sync  <= '0;
         data_sync <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         tmo_cnt   <= '0;
         rx_byte   <= '0;
         rx_stb    <= 1'b0;
         rx_err    <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[1:0], ps2_data};
         rx_stb    <= 1'b0;
         rx_err    <= 1'b0;
         if (fall) begin
            tmo_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= '0;
               rx_byte <= frame[8:1];
               rx_stb  <= frame_good | ~CHECK;
               rx_err  <= ~frame_good & CHECK;
            end else begin
               shift   <= {data_sync[2], shift[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            // A stalled partial frame is silently abandoned.
            if (tmo_cnt == TMO_LAST) begin
               bit_cnt <= '0;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 key decoder: frame receiver, byte FIFO, E0/F0 prefix FSM, repeat filter.
// Define PS2_PARITY_CHECK_EN to reject malformed frames and pulse parity_err.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   input  logic             key_ready,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_release,
   output logic             key_held,
   output logic [CNT_W-1:0] press_count,
   output logic             overflow,
   output logic             parity_err
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  rx_byte;
   logic        rx_stb;
   logic        rx_err;

   logic [7:0]  fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic [7:0]  pop_byte;

   dec_state_t  state;
   key_event_t  evt;
   logic [7:0]  held_code;
   logic        held_ext;
   logic        st_ext;
   logic        st_brk;
   logic        held_match;

   ps2_rx_frame #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_rx (
      .clk     (clk),
      .clrn    (clrn),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .rx_byte (rx_byte),
      .rx_stb  (rx_stb),
      .rx_err  (rx_err)
   );

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop        = ~fifo_empty & (~key_valid | key_ready);
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign push       = rx_stb & (~fifo_full | pop);
   assign pop_byte   = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!clrn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= rx_byte;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rx_stb && !push) overflow <= 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         parity_err <= rx_err;
      end
   end

   assign st_ext     = (state == ST_EXT) || (state == ST_EXT_BRK);
   assign st_brk     = (state == ST_BRK) || (state == ST_EXT_BRK);
   assign held_match = (held_code == pop_byte) && (held_ext == st_ext);

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state       <= ST_IDLE;
         key_valid   <= 1'b0;
         evt         <= '0;
         key_held    <= 1'b0;
         held_code   <= '0;
         held_ext    <= 1'b0;
         press_count <= '0;
      end else begin
         if (key_valid && key_ready) key_valid <= 1'b0;
         if (pop) begin
            if (pop_byte == PS2_EXT) begin
               // E0 after F0 is a protocol error: drop it and resynchronise.
               state <= st_brk ? ST_IDLE : ST_EXT;
            end else if (pop_byte == PS2_BRK) begin
               state <= st_ext ? ST_EXT_BRK : ST_BRK;
            end else begin
               state <= ST_IDLE;
               if (!is_err_code(pop_byte)) begin
                  if (st_brk) begin
                     key_valid <= 1'b1;
                     evt       <= '{code: pop_byte, ext: st_ext, is_release: 1'b1};
                     if (held_match) key_held <= 1'b0;
                  end else if (!(key_held && held_match)) begin
                     key_valid   <= 1'b1;
                     evt         <= '{code: pop_byte, ext: st_ext, is_release: 1'b0};
                     key_held    <= 1'b1;
                     held_code   <= pop_byte;
                     held_ext    <= st_ext;
                     press_count <= press_count + 1'b1;
                  end
               end
            end
         end
      end
   end

   assign key_code    = evt.code;
   assign key_ext     = evt.ext;
   assign key_release = evt.is_release;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus randomized key traffic
// compared against a prefix/repeat-filter reference model.
module tb_ps2_key_decoder;

   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W      = 8;
   localparam int TMO        = 300;
   localparam int HALF       = 10;

   logic             clk = 1'b0;
   logic             clrn = 1'b0;
   logic             ps2_clk = 1'b1;
   logic             ps2_data = 1'b1;
   logic             key_ready = 1'b0;
   logic             key_valid;
   logic [7:0]       key_code;
   logic             key_ext;
   logic             key_release;
   logic             key_held;
   logic [CNT_W-1:0] press_count;
   logic             overflow;
   logic             parity_err;

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ev_t;

   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;
   int   perr_pulses = 0;
   ev_t  got_q[$];
   ev_t  exp_q[$];
   time  first_valid_t = 0;
   time  last_fall_t = 0;
   logic hold_pend = 1'b0;
   logic [9:0] hold_ev = '0;

   // Reference model state: pending prefixes and the last key that went down.
   bit         m_ext, m_brk, m_held, m_hext;
   logic [7:0] m_hcode;
   int         m_cnt;

   ps2_key_decoder #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_ready  (key_ready),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_release(key_release),
      .key_held   (key_held),
      .press_count(press_count),
      .overflow   (overflow),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (hold_pend && clrn)
         check("hold_stable", {22'd0, key_valid, key_ext, key_release, key_code}, {22'd0, 1'b1, hold_ev});
      hold_pend = key_valid && !key_ready && clrn;
      hold_ev   = {key_ext, key_release, key_code};
      if (key_valid && first_valid_t == 0) first_valid_t = $time;
      if (key_valid && key_ready) got_q.push_back('{key_code, key_ext, key_release});
      if (parity_err) perr_pulses++;
   end

   initial begin
      forever begin
         @(posedge clk);
         #3;
         case (ready_mode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            default: key_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(HALF);
      ps2_clk = 1'b0;
      last_fall_t = $time;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit flip);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ flip, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(f[i]);
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) begin
         if (m_brk) begin m_ext = 0; m_brk = 0; end
         else m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (b != 8'h00 && b != 8'hFF) begin
            if (m_brk) begin
               exp_q.push_back('{b, m_ext, 1'b1});
               if (m_hcode == b && m_hext == m_ext) m_held = 0;
            end else if (!(m_held && m_hcode == b && m_hext == m_ext)) begin
               exp_q.push_back('{b, m_ext, 1'b0});
               m_held = 1; m_hcode = b; m_hext = m_ext;
               m_cnt++;
            end
         end
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      model_byte(b);
      send_frame(b, 1'b0);
   endtask

   task automatic do_reset(input bit chk);
      clrn = 1'b0;
      tick(3);
      if (chk) begin
         check("rst_valid", {31'd0, key_valid}, 32'd0);
         check("rst_event", {22'd0, key_code, key_ext, key_release}, 32'd0);
         check("rst_count", {24'd0, press_count}, 32'd0);
         check("rst_flags", {29'd0, key_held, overflow, parity_err}, 32'd0);
      end
      clrn = 1'b1;
      tick(2);
      got_q.delete(); exp_q.delete();
      perr_pulses = 0;
      m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = '0; m_cnt = 0;
   endtask

   task automatic wait_events();
      for (int i = 0; i < 4000 && got_q.size() < exp_q.size(); i++) tick(1);
      tick(40);
   endtask

   task automatic compare_events(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check(tag, {22'd0, got_q[i].ext, got_q[i].rel, got_q[i].code},
                    {22'd0, exp_q[i].ext, exp_q[i].rel, exp_q[i].code});
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      longint lat;
      logic [7:0] pool [4];
      logic [7:0] c;
      pool[0] = 8'h1C; pool[1] = 8'h29; pool[2] = 8'h75; pool[3] = 8'h5A;

      // Reset state
      do_reset(1'b1);

      // Single make: latency from final pin edge, event content, count and held flag
      ready_mode = 1;
      first_valid_t = 0;
      push_byte(8'h1C);
      lat = longint'(first_valid_t) - longint'(last_fall_t);
      check("latency_window", {31'd0, (lat >= 35 && lat <= 65)}, 32'd1);
      wait_events();
      compare_events("make_1c");
      check("make_count", {24'd0, press_count}, 32'd1);
      check("make_held", {31'd0, key_held}, 32'd1);

      // Typematic repeats suppressed, then break
      do_reset(1'b0);
      push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
      push_byte(8'hF0); push_byte(8'h1C);
      wait_events();
      compare_events("repeat");
      check("repeat_count", {24'd0, press_count}, 32'd1);
      check("repeat_held", {31'd0, key_held}, 32'd0);

      // Extended break
      do_reset(1'b0);
      push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
      wait_events();
      compare_events("ext_break");

      // Stalled consumer: one event in the output register plus a full FIFO, then a drop
      do_reset(1'b0);
      ready_mode = 0;
      for (int i = 0; i < FIFO_DEPTH + 1; i++) push_byte(8'h11 + 8'(i));
      tick(10);
      check("full_no_ovf", {31'd0, overflow}, 32'd0);
      check("stall_valid", {31'd0, key_valid}, 32'd1);
      send_frame(8'h3A, 1'b0);
      tick(10);
      check("ovf_set", {31'd0, overflow}, 32'd1);
      ready_mode = 1;
      wait_events();
      compare_events("drain");
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      check("drain_count", {24'd0, press_count}, 32'(m_cnt));

      // Bad parity frame
      do_reset(1'b0);
`ifdef PS2_PARITY_CHECK_EN
      send_frame(8'h1C, 1'b1);
      tick(40);
      check("perr_pulse", perr_pulses, 32'd1);
      check("perr_no_event", got_q.size(), 32'd0);
`else
      model_byte(8'h1C);
      send_frame(8'h1C, 1'b1);
      wait_events();
      check("perr_tied", perr_pulses, 32'd0);
      compare_events("noparity");
`endif

      // Partial frame abandoned by timeout
      do_reset(1'b0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      tick(TMO + 20);
      push_byte(8'h29);
      wait_events();
      compare_events("timeout");

      // Reset in the middle of a frame with buffered data
      do_reset(1'b0);
      ready_mode = 0;
      send_frame(8'h33, 1'b0);
      send_frame(8'h34, 1'b0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      check("pre_rst_valid", {31'd0, key_valid}, 32'd1);
      do_reset(1'b1);
      ready_mode = 1;
      tick(100);
      check("post_rst_empty", got_q.size(), 32'd0);
      push_byte(8'h35);
      wait_events();
      compare_events("post_rst");

      // Randomized key traffic with a random consumer
      do_reset(1'b0);
      ready_mode = 2;
      for (int n = 0; n < 40; n++) begin
         c = pool[$urandom_range(0, 3)];
         if ($urandom_range(0, 9) == 0) push_byte(8'h00);
         if ($urandom_range(0, 1) == 1) push_byte(8'hE0);
         if ($urandom_range(0, 2) == 0) push_byte(8'hF0);
         push_byte(c);
      end
      wait_events();
      compare_events("random");
      check("random_count", {24'd0, press_count}, 32'(m_cnt % 256));
      check("random_held", {31'd0, key_held}, {31'd0, m_held});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
